// File: rtl/alu_seq_if.sv
// Nibble-entry ALU bus: operand/opcode strobe in, result and status out.
interface alu_seq_if #(
  parameter int W = 8
);
  logic [3:0]     Datain;
  logic           readNext;
  logic [2*W-1:0] Y;
  logic           busy;
  logic           done;
  logic           err;
  logic [2:0]     state;

  modport master (
    output Datain, readNext,
    input  Y, busy, done, err, state
  );

  modport slave (
    input  Datain, readNext,
    output Y, busy, done, err, state
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: operands and opcode entered a nibble per button press,
// multi-cycle shift-add MUL and restoring DIV, result held until next press.
module alu_seq_unit #(
  parameter int W = 8
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int NW = (W / 4 > 1) ? $clog2(W / 4) : 1;
  localparam int CW = $clog2(W);
  localparam logic [NW-1:0] NLAST = NW'(W / 4 - 1);
  localparam logic [NW-1:0] NONE  = NW'(1);
  localparam logic [CW-1:0] CLAST = CW'(W - 1);
  localparam logic [CW-1:0] CONE  = CW'(1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         st;
  logic           rn_q;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [3:0]     op;
  logic [NW-1:0]  nib;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] p;
  logic [2*W-1:0] y;
  logic           busy;
  logic           done;
  logic           err;

  logic           press;
  logic [W+3:0]   a_cat;
  logic [W+3:0]   b_cat;
  logic [2*W-1:0] res;
  logic           res_err;
  logic           multi;
  logic [W:0]     msum;
  logic [W:0]     dsh;
  logic [W:0]     ddif;
  logic [2*W-1:0] p_nx;

  assign press = bus.readNext & ~rn_q;
  assign a_cat = {a, bus.Datain};
  assign b_cat = {b, bus.Datain};
  assign multi = (op == 4'd3) | ((op == 4'd4) & (b != '0));

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op)
      4'd0: res[2:0] = {a > b, a == b, a < b};
      4'd1: res[W:0] = {1'b0, a} + {1'b0, b};
      4'd2: res[W:0] = {1'b0, a} - {1'b0, b};
      4'd3: ;
      // only reached with b == 0; nonzero divisors iterate
      4'd4: begin
        res     = {a, {W{1'b1}}};
        res_err = 1'b1;
      end
      4'd5: res[W-1:0] = a & b;
      4'd6: res[W-1:0] = a | b;
      4'd7: res[W-1:0] = a ^ b;
      default: res_err = 1'b1;
    endcase
  end

  // p is {hi, lo}: product accumulator for MUL, {remainder, quotient} for DIV
  always_comb begin
    msum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : '0);
    dsh  = {p[2*W-1:W], p[W-1]};
    ddif = dsh - {1'b0, b};
    if (op == 4'd3)
      p_nx = {msum, p[W-1:1]};
    else if (ddif[W])
      p_nx = {dsh[W-1:0], p[W-2:0], 1'b0};
    else
      p_nx = {ddif[W-1:0], p[W-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= LOAD_A;
      rn_q <= 1'b1;
      a    <= '0;
      b    <= '0;
      op   <= '0;
      nib  <= '0;
      cnt  <= '0;
      p    <= '0;
      y    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      rn_q <= bus.readNext;
      case (st)
        LOAD_A: if (press) begin
          a <= a_cat[W-1:0];
          if (nib == NLAST) begin
            nib <= '0;
            st  <= LOAD_B;
          end else begin
            nib <= nib + NONE;
          end
        end
        LOAD_B: if (press) begin
          b <= b_cat[W-1:0];
          if (nib == NLAST) begin
            nib <= '0;
            st  <= LOAD_OP;
          end else begin
            nib <= nib + NONE;
          end
        end
        LOAD_OP: if (press) begin
          op <= bus.Datain;
          st <= EXEC;
        end
        EXEC: begin
          if (busy) begin
            p <= p_nx;
            if (cnt == CLAST) begin
              cnt  <= '0;
              busy <= 1'b0;
              y    <= p_nx;
              done <= 1'b1;
              st   <= DONE;
            end else begin
              cnt <= cnt + CONE;
            end
          end else if (multi) begin
            busy <= 1'b1;
            p    <= {{W{1'b0}}, (op == 4'd3) ? b : a};
          end else begin
            y    <= res;
            err  <= res_err;
            done <= 1'b1;
            st   <= DONE;
          end
        end
        DONE: if (press) begin
          done <= 1'b0;
          err  <= 1'b0;
          a    <= a_cat[W-1:0];
          if (W == 4) begin
            st <= LOAD_B;
          end else begin
            nib <= NONE;
            st  <= LOAD_A;
          end
        end
        default: st <= LOAD_A;
      endcase
    end
  end

  assign bus.Y     = y;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.err   = err;
  assign bus.state = st;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (W=8): nibble entry, all op classes,
// latency, reset mid-MUL, held strobe and strobes during a busy DIV.
module tb_alu_seq_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   nbusy;

  alu_seq_if #(.W(8)) bus ();

  alu_seq_unit #(.W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] n);
    bus.Datain   = n;
    bus.readNext = 1'b1;
    tick;
    bus.readNext = 1'b0;
    tick;
  endtask

  task automatic load(input logic [7:0] av, input logic [7:0] bv);
    press(av[7:4]);
    press(av[3:0]);
    press(bv[7:4]);
    press(bv[3:0]);
  endtask

  task automatic run_op(input logic [3:0] opc, input bit jam,
                        output int l, output int nb);
    bus.Datain   = opc;
    bus.readNext = 1'b1;
    tick;
    bus.readNext = 1'b0;
    l  = 1;
    nb = 0;
    while (!bus.done && l < 40) begin
      if (jam) begin
        bus.readNext = l[0];
        bus.Datain   = 4'hF;
      end
      tick;
      l++;
      if (bus.busy) nb++;
    end
    bus.readNext = 1'b0;
    tick;
  endtask

  initial begin
    reset        = 1'b1;
    bus.readNext = 1'b0;
    bus.Datain   = 4'h0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("rst_state", bus.state, 0);
    chk("rst_y", bus.Y, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);

    load(8'h45, 8'h52);
    chk("ld_state", bus.state, 2);
    run_op(4'd1, 1'b0, lat, nbusy);
    chk("add_y", bus.Y, 32'h0097);
    chk("add_err", bus.err, 0);
    chk("add_lat", lat, 2);
    chk("add_state", bus.state, 4);
    chk("add_hold", bus.done, 1);

    load(8'hFF, 8'hFF);
    run_op(4'd3, 1'b0, lat, nbusy);
    chk("mul_y", bus.Y, 32'hFE01);
    chk("mul_lat", lat, 10);
    chk("mul_busy", nbusy, 8);
    chk("mul_err", bus.err, 0);

    load(8'hC8, 8'h07);
    run_op(4'd4, 1'b1, lat, nbusy);
    chk("div_y", bus.Y, 32'h041C);
    chk("div_lat", lat, 10);
    chk("div_err", bus.err, 0);
    chk("div_state", bus.state, 4);

    load(8'h12, 8'h00);
    run_op(4'd4, 1'b0, lat, nbusy);
    chk("dz_y", bus.Y, 32'h12FF);
    chk("dz_err", bus.err, 1);
    chk("dz_lat", lat, 2);
    chk("dz_busy", nbusy, 0);

    load(8'h03, 8'h05);
    run_op(4'd2, 1'b0, lat, nbusy);
    chk("sub_y", bus.Y, 32'h01FE);
    chk("sub_err", bus.err, 0);
    load(8'h03, 8'h05);
    run_op(4'd0, 1'b0, lat, nbusy);
    chk("cmp_y", bus.Y, 32'h0001);
    load(8'h03, 8'h05);
    run_op(4'd9, 1'b0, lat, nbusy);
    chk("ill_y", bus.Y, 0);
    chk("ill_err", bus.err, 1);
    chk("ill_lat", lat, 2);

    load(8'hFF, 8'h01);
    run_op(4'd1, 1'b0, lat, nbusy);
    chk("carry_y", bus.Y, 32'h0100);

    load(8'hFF, 8'hFF);
    bus.Datain   = 4'd3;
    bus.readNext = 1'b1;
    tick;
    bus.readNext = 1'b0;
    tick;
    tick;
    tick;
    chk("mid_busy", bus.busy, 1);
    reset        = 1'b1;
    bus.readNext = 1'b1;
    bus.Datain   = 4'hF;
    tick;
    chk("mr_busy", bus.busy, 0);
    chk("mr_state", bus.state, 0);
    chk("mr_y", bus.Y, 0);
    chk("mr_done", bus.done, 0);
    reset = 1'b0;
    tick;
    tick;
    chk("held_state", bus.state, 0);
    bus.readNext = 1'b0;
    tick;
    bus.Datain   = 4'h1;
    bus.readNext = 1'b1;
    repeat (50) tick;
    bus.readNext = 1'b0;
    tick;
    chk("hold50_st", bus.state, 0);
    press(4'h2);
    chk("hold50_b", bus.state, 1);
    press(4'h3);
    press(4'h4);
    run_op(4'd1, 1'b0, lat, nbusy);
    chk("post_rst_y", bus.Y, 32'h0046);

    press(4'hC);
    chk("dn_done", bus.done, 0);
    chk("dn_err", bus.err, 0);
    chk("dn_y", bus.Y, 32'h0046);
    chk("dn_state", bus.state, 0);
    press(4'h3);
    press(4'h5);
    press(4'hA);
    run_op(4'd5, 1'b0, lat, nbusy);
    chk("and_y", bus.Y, 32'h0042);
    load(8'hC3, 8'h5A);
    run_op(4'd6, 1'b0, lat, nbusy);
    chk("or_y", bus.Y, 32'h00DB);
    load(8'hC3, 8'h5A);
    run_op(4'd7, 1'b0, lat, nbusy);
    chk("xor_y", bus.Y, 32'h0099);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter W, default 8, operand width in bits; SHALL be a multiple of 4, range 4..16.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Datain  input  4  nibble loaded on each accepted readNext edge.
REQ-005 readNext  input  1  level strobe (push-button); the block SHALL act only on its 0->1 transition.
REQ-006 Y  output  2W  registered result.
REQ-007 busy  output  1  high while a multi-cycle operation executes.
REQ-008 done  output  1  high while Y holds a valid result.
REQ-009 err  output  1  high with done for divide-by-zero or illegal opcode.
REQ-010 state  output  3  current FSM state code, for debug LEDs.

Function
REQ-011 Edge detect: a registered copy of readNext; an edge is readNext=1 while the copy is 0; one edge per press regardless of hold length.
REQ-012 FSM states and codes: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, DONE=4; codes 5-7 unused and SHALL return to LOAD_A.
REQ-013 LOAD_A: each edge shifts Datain into A, MS nibble first (A <= {A[W-5:0], Datain}); after W/4 edges, go to LOAD_B.
REQ-014 LOAD_B: identical to LOAD_A, targeting B; after W/4 edges, go to LOAD_OP.
REQ-015 LOAD_OP: one edge latches Datain as opcode and enters EXEC on the next clock.
REQ-016 Opcodes: 0 CMP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 XOR; 8-15 illegal.
REQ-017 CMP: Y = {2W-3 zeros, A>B, A==B, A<B}, unsigned compare.
REQ-018 ADD: Y[W:0] = A+B with Y[W] = carry out; upper bits zero.
REQ-019 SUB: Y[W-1:0] = (A-B) mod 2^W, Y[W] = borrow (A<B); upper bits zero.
REQ-020 AND/OR/XOR: Y[W-1:0] = bitwise result; upper bits zero.
REQ-021 Single-cycle ops (CMP, ADD, SUB, logic, illegal) SHALL spend one cycle in EXEC; done=1 on the following cycle.
REQ-022 MUL: unsigned shift-add, one bit per cycle; busy=1 for W cycles; Y = full 2W-bit product.
REQ-023 DIV: unsigned restoring division, one bit per cycle; busy=1 for W cycles; Y = {remainder[W-1:0], quotient[W-1:0]}.
REQ-024 DIV with B=0: no iteration; done and err asserted one cycle after EXEC entry; Y = {A, all-ones}.
REQ-025 Illegal opcode: Y=0, err=1, done after one EXEC cycle.
REQ-026 Latency: from the opcode edge cycle, done SHALL rise 2 cycles later for single-cycle ops and W+2 cycles later for MUL/DIV.
REQ-027 Y, done, and err SHALL be updated only on the EXEC->DONE transition and SHALL hold while in DONE.
REQ-028 Edges during EXEC SHALL be ignored and SHALL NOT be queued.
REQ-029 An edge in DONE SHALL clear done and err, hold Y, load Datain as the first A nibble, and enter LOAD_A (or LOAD_B if W=4).
REQ-030 The operand and iteration counters SHALL be ceil(log2) sized and SHALL wrap to zero when leaving their state.

Reset
REQ-031 On reset=1 at a clock edge: state=LOAD_A, A=B=opcode=0, Y=0, busy=done=err=0, counters=0; the edge-detect copy SHALL be set to 1 so that a held readNext does not count.
REQ-032 Reset SHALL have priority over every other event, including mid-MUL/DIV and a simultaneous edge; the next operation starts from the first A nibble.

Verification (W=8)
REQ-033 Nibbles 4,5,5,2,1 -> Y=0x0097, err=0, done 2 cycles after the 5th edge.
REQ-034 A=0xFF, B=0xFF, op 3 -> busy high 8 cycles, then Y=0xFE01, done at +10 cycles.
REQ-035 A=0xC8, B=0x07, op 4 -> Y=0x041C (q=28, r=4); then A=0x12, B=0x00, op 4 -> Y=0x12FF, err=1, no busy.
REQ-036 A=0x03, B=0x05, op 2 -> Y=0x01FE; op 0 with the same operands -> Y=0x0001; op 9 -> Y=0, err=1.
REQ-037 Reset pulsed 3 cycles into a MUL -> busy=0, state=0, Y=0 on the next cycle; readNext held high through reset SHALL load no nibble.
REQ-038 readNext held high for 50 cycles in LOAD_A -> exactly one nibble loaded; edges during DIV busy SHALL leave the result unchanged.
